// File: rtl/shift_mul_seq.sv
// Sequential radix-2^RADIX_BITS shift-and-add multiplier for the RV32 shift path.
// Selects the low or high product word and optionally bit-reverses it.
module shift_mul_seq #(
    parameter int unsigned RADIX_BITS = 4,
    parameter bit          EARLY_TERM = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [31:0] in_shift,
    input  logic        in_right,
    input  logic        in_hi,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy
);

    localparam int unsigned     NDIG  = 32 / RADIX_BITS;
    localparam int unsigned     CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [63:0]      acc;
    logic [63:0]      mcand;
    logic [31:0]      mplier;
    logic [CNT_W-1:0] cnt;
    logic             right_q;
    logic             hi_q;

    logic [63:0]      pp;
    logic [63:0]      acc_nxt;
    logic [31:0]      mplier_nxt;
    logic             run_last;
    logic [31:0]      res_word;

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

    // One digit of the multiplier scales the shifted multiplicand; the result
    // word is formed from the post-update accumulator so it can be registered
    // on the same edge that enters DONE.
    always_comb begin
        pp = '0;
        for (int unsigned i = 0; i < RADIX_BITS; i++) begin
            if (mplier[i]) begin
                pp = pp + (mcand << i);
            end
        end
        acc_nxt    = acc + pp;
        mplier_nxt = mplier >> RADIX_BITS;
        run_last   = (cnt == LAST) || (EARLY_TERM && (mplier_nxt == '0));
        res_word   = hi_q ? acc_nxt[63:32] : acc_nxt[31:0];
        if (right_q) begin
            res_word = bitrev32(res_word);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            out_result <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            right_q    <= 1'b0;
            hi_q       <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mcand    <= {32'b0, in_data};
                        mplier   <= in_shift;
                        right_q  <= in_right;
                        hi_q     <= in_hi;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << RADIX_BITS;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (run_last) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= res_word;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
